// File: rtl/ysyx_220066_mem_access.sv
// ysyx_220066_mem_access: RV64 memory-access stage issuing aligned 64-bit bus beats
// and handing writeback a registered bundle carrying the raw read beat.
module ysyx_220066_mem_access #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wen_in,
    input  logic              MemRd_in,
    input  logic              MemWr_in,
    input  logic              done_in,
    input  logic              error_in,
    input  logic [2:0]        MemOp_in,
    input  logic [4:0]        rd_in,
    input  logic [63:0]       alu_in,
    input  logic [63:0]       store_in,
    input  logic [63:0]       nxtpc_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    output logic [7:0]        dmem_wmask,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [63:0]       dmem_rdata,
    input  logic              dmem_err,
    output logic              out_valid,
    output logic              out_wen,
    output logic              out_MemRd,
    output logic              out_MemWr,
    output logic              out_done,
    output logic              out_error,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_MemOp,
    output logic [2:0]        out_addr_low,
    output logic [63:0]       out_data,
    output logic [63:0]       out_rdata,
    output logic [63:0]       out_nxtpc
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          lt_wen, lt_memrd, lt_memwr, lt_done;
    logic [2:0]    lt_memop;
    logic [4:0]    lt_rd;
    logic [63:0]   lt_alu, lt_store, lt_nxtpc;
    logic          mem_op, mis, err_now, go_mem, idle_out, to_hit, resp, fin, fin_err;
    logic [1:0]    sz;
    logic [2:0]    a;
    assign mem_op   = MemRd_in | MemWr_in;
    assign mis      = (MemOp_in[1:0] == 2'd1 && alu_in[0]) ||
                      (MemOp_in[1:0] == 2'd2 && |alu_in[1:0]) ||
                      (MemOp_in[1:0] == 2'd3 && |alu_in[2:0]);
    assign err_now  = error_in | (mem_op & mis);
    assign go_mem   = mem_op && !err_now;
    assign idle_out = state == IDLE && in_valid && !go_mem;
    assign to_hit   = cnt == CW'(TIMEOUT);
    assign resp     = state == WAIT && dmem_rvalid;
    assign fin      = resp || (state == REQ && !dmem_gnt && to_hit) || (state == WAIT && to_hit);
    assign fin_err  = resp ? dmem_err : 1'b1;
    assign in_ready = state == IDLE;
    assign sz         = lt_memop[1:0];
    assign a          = lt_alu[2:0];
    assign dmem_addr  = {lt_alu[ADDR_W-1:3], 3'b000};
    assign dmem_wmask = sz == 2'd0 ? 8'h01 << a :
                        sz == 2'd1 ? 8'h03 << {a[2:1], 1'b0} :
                        sz == 2'd2 ? 8'h0F << {a[2], 2'b00} : 8'hFF;
    assign dmem_wdata = sz == 2'd0 ? {8{lt_store[7:0]}} :
                        sz == 2'd1 ? {4{lt_store[15:0]}} :
                        sz == 2'd2 ? {2{lt_store[31:0]}} : lt_store;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            lt_wen       <= 1'b0;
            lt_memrd     <= 1'b0;
            lt_memwr     <= 1'b0;
            lt_done      <= 1'b0;
            lt_memop     <= '0;
            lt_rd        <= '0;
            lt_alu       <= '0;
            lt_store     <= '0;
            lt_nxtpc     <= '0;
            out_valid    <= 1'b0;
            out_wen      <= 1'b0;
            out_MemRd    <= 1'b0;
            out_MemWr    <= 1'b0;
            out_done     <= 1'b0;
            out_error    <= 1'b0;
            out_rd       <= '0;
            out_MemOp    <= '0;
            out_addr_low <= '0;
            out_data     <= '0;
            out_rdata    <= '0;
            out_nxtpc    <= '0;
        end else begin
            out_valid <= idle_out || fin;
            if (idle_out) begin
                out_wen      <= wen_in & ~err_now;
                out_error    <= err_now;
                out_MemRd    <= MemRd_in;
                out_MemWr    <= MemWr_in;
                out_done     <= done_in;
                out_rd       <= rd_in;
                out_MemOp    <= MemOp_in;
                out_addr_low <= alu_in[2:0];
                out_data     <= alu_in;
                out_rdata    <= '0;
                out_nxtpc    <= nxtpc_in;
            end
            // Completion from the bus side, either a response beat or a timeout
            if (fin) begin
                out_wen      <= lt_wen & ~fin_err;
                out_error    <= fin_err;
                out_MemRd    <= lt_memrd;
                out_MemWr    <= lt_memwr;
                out_done     <= lt_done;
                out_rd       <= lt_rd;
                out_MemOp    <= lt_memop;
                out_addr_low <= lt_alu[2:0];
                out_data     <= lt_alu;
                out_rdata    <= resp ? dmem_rdata : '0;
                out_nxtpc    <= lt_nxtpc;
                state        <= IDLE;
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
            end
            case (state)
                IDLE: if (in_valid && go_mem) begin
                    lt_wen   <= wen_in;
                    lt_memrd <= MemRd_in;
                    lt_memwr <= MemWr_in;
                    lt_done  <= done_in;
                    lt_memop <= MemOp_in;
                    lt_rd    <= rd_in;
                    lt_alu   <= alu_in;
                    lt_store <= store_in;
                    lt_nxtpc <= nxtpc_in;
                    state    <= REQ;
                    cnt      <= '0;
                    dmem_req <= 1'b1;
                    dmem_we  <= MemWr_in;
                end
                REQ: if (dmem_gnt) begin
                    state    <= WAIT;
                    cnt      <= '0;
                    dmem_req <= 1'b0;
                end else if (!to_hit) cnt <= cnt + CW'(1);
                WAIT: if (!fin) cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_220066_mem_access.sv
// tb_ysyx_220066_mem_access: directed bench for the memory-access stage
module tb_ysyx_220066_mem_access;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wen_in, MemRd_in, MemWr_in, done_in, error_in;
  logic [2:0]  MemOp_in;
  logic [4:0]  rd_in;
  logic [63:0] alu_in, store_in, nxtpc_in;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;
  logic        out_valid, out_wen, out_MemRd, out_MemWr, out_done, out_error;
  logic [4:0]  out_rd;
  logic [2:0]  out_MemOp, out_addr_low;
  logic [63:0] out_data, out_rdata, out_nxtpc;
  int checks = 0;
  int errors = 0;
  int n;
  ysyx_220066_mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wen_in(wen_in), .MemRd_in(MemRd_in), .MemWr_in(MemWr_in), .done_in(done_in),
    .error_in(error_in), .MemOp_in(MemOp_in), .rd_in(rd_in), .alu_in(alu_in),
    .store_in(store_in), .nxtpc_in(nxtpc_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dmem_err(dmem_err), .out_valid(out_valid), .out_wen(out_wen), .out_MemRd(out_MemRd),
    .out_MemWr(out_MemWr), .out_done(out_done), .out_error(out_error), .out_rd(out_rd),
    .out_MemOp(out_MemOp), .out_addr_low(out_addr_low), .out_data(out_data),
    .out_rdata(out_rdata), .out_nxtpc(out_nxtpc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] d, input logic w);
    in_valid = 1'b1; MemRd_in = rd_op; MemWr_in = wr_op; MemOp_in = op;
    alu_in = a; store_in = d; wen_in = w;
    step();
    in_valid = 1'b0; MemRd_in = 1'b0; MemWr_in = 1'b0;
  endtask
  task automatic do_store(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] em, input logic [63:0] ew);
    issue(1'b0, 1'b1, op, a, d, 1'b0);
    chk("st_req", dmem_req, 1'b1);
    chk("st_mask", dmem_wmask, em);
    chk("st_wdata", dmem_wdata, ew);
    chk("st_we", dmem_we, 1'b1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("st_done", out_valid, 1'b1);
  endtask
  initial begin
    rst = 1'b0; in_valid = 1'b0; wen_in = 1'b0; MemRd_in = 1'b0; MemWr_in = 1'b0;
    done_in = 1'b0; error_in = 1'b0; MemOp_in = 3'd0; rd_in = 5'd0; alu_in = 64'd0;
    store_in = 64'd0; nxtpc_in = 64'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = 64'd0; dmem_err = 1'b0;
    step(); step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_data", out_data, 64'd0);
    rst = 1'b1;
    step();
    rd_in = 5'd5; nxtpc_in = 64'h8000_0004;
    issue(1'b0, 1'b0, 3'd3, 64'h1234, 64'd0, 1'b1);
    chk("add_valid", out_valid, 1'b1);
    chk("add_wen", out_wen, 1'b1);
    chk("add_rd", out_rd, 5'd5);
    chk("add_data", out_data, 64'h1234);
    chk("add_nxtpc", out_nxtpc, 64'h8000_0004);
    chk("add_ready", in_ready, 1'b1);
    step();
    chk("add_pulse", out_valid, 1'b0);
    rd_in = 5'd7;
    issue(1'b1, 1'b0, 3'd0, 64'h8000_0003, 64'd0, 1'b1);
    chk("lb_req", dmem_req, 1'b1);
    chk("lb_addr", dmem_addr, 64'h8000_0000);
    chk("lb_we", dmem_we, 1'b0);
    chk("lb_ready", in_ready, 1'b0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("lb_req_drop", dmem_req, 1'b0);
    chk("lb_early", out_valid, 1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = 64'h1122334455667788;
    step();
    dmem_rvalid = 1'b0;
    chk("lb_valid", out_valid, 1'b1);
    chk("lb_rdata", out_rdata, 64'h1122334455667788);
    chk("lb_low", out_addr_low, 3'd3);
    chk("lb_memop", out_MemOp, 3'd0);
    chk("lb_wen", out_wen, 1'b1);
    chk("lb_err", out_error, 1'b0);
    chk("lb_rd", out_rd, 5'd7);
    issue(1'b0, 1'b1, 3'd1, 64'h8000_0006, 64'hABCD, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", dmem_req, 1'b1);
      chk("sh_addr", dmem_addr, 64'h8000_0000);
      chk("sh_mask", dmem_wmask, 8'hC0);
      chk("sh_wdata", dmem_wdata, 64'hABCDABCDABCDABCD);
      chk("sh_we", dmem_we, 1'b1);
      chk("sh_ready", in_ready, 1'b0);
      step();
    end
    dmem_gnt = 1'b1;
    chk("sh_req_gnt", dmem_req, 1'b1);
    step();
    dmem_gnt = 1'b0;
    chk("sh_ready_wait", in_ready, 1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = 64'd0;
    step();
    dmem_rvalid = 1'b0;
    chk("sh_valid", out_valid, 1'b1);
    chk("sh_err", out_error, 1'b0);
    chk("sh_memwr", out_MemWr, 1'b1);
    do_store(3'd0, 64'h8000_0015, 64'h5A, 8'h20, 64'h5A5A5A5A5A5A5A5A);
    do_store(3'd2, 64'h8000_0004, 64'hFFFF_FFFF_DEAD_BEEF, 8'hF0, 64'hDEADBEEF_DEADBEEF);
    do_store(3'd3, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
    issue(1'b1, 1'b0, 3'd2, 64'h8000_0002, 64'd0, 1'b1);
    chk("mis_valid", out_valid, 1'b1);
    chk("mis_err", out_error, 1'b1);
    chk("mis_wen", out_wen, 1'b0);
    chk("mis_req", dmem_req, 1'b0);
    step();
    chk("mis_req2", dmem_req, 1'b0);
    chk("mis_pulse", out_valid, 1'b0);
    issue(1'b1, 1'b0, 3'd3, 64'h8000_0008, 64'd0, 1'b1);
    chk("to_req", dmem_req, 1'b1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 300);
    chk("to_cycles", (n >= 255 && n <= 256), 1'b1);
    chk("to_valid", out_valid, 1'b1);
    chk("to_err", out_error, 1'b1);
    chk("to_wen", out_wen, 1'b0);
    chk("to_ready", in_ready, 1'b1);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("late_rvalid", out_valid, 1'b0);
    chk("late_ready", in_ready, 1'b1);
    issue(1'b1, 1'b0, 3'd3, 64'h8000_0010, 64'd0, 1'b1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_err = 1'b1;
    step();
    dmem_rvalid = 1'b0; dmem_err = 1'b0;
    chk("berr_valid", out_valid, 1'b1);
    chk("berr_err", out_error, 1'b1);
    chk("berr_wen", out_wen, 1'b0);
    issue(1'b1, 1'b0, 3'd3, 64'h8000_0018, 64'd0, 1'b1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("wait_ready", in_ready, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_req", dmem_req, 1'b0);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_ready", in_ready, 1'b1);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("mrst_nodeliver", out_valid, 1'b0);
    rd_in = 5'd9;
    issue(1'b0, 1'b0, 3'd3, 64'h55, 64'd0, 1'b1);
    chk("post_valid", out_valid, 1'b1);
    chk("post_data", out_data, 64'h55);
    chk("post_rd", out_rd, 5'd9);
    chk("post_err", out_error, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_220066_mem_access.md
Name: ysyx_220066_mem_access

Overview:
Memory-access stage of the RV64 pipeline, directly upstream of the writeback stage. Takes one instruction at a time from execute and issues aligned 64-bit load/store transactions on the data bus with byte-lane write masks. Captures the raw 64-bit read beat and hands WB a registered bundle: raw read data, MemOp, address low bits, rd, wen, ALU result, next PC and error. Byte/half/word extraction and sign extension are done in WB.

Parameters:
TIMEOUT, 255, max cycles waiting for a bus grant or response before flagging error
ADDR_W, 64, address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  execute presents an instruction
in_ready  out  1  stage can accept this cycle
wen_in  in  1  instruction writes rd
MemRd_in  in  1  load
MemWr_in  in  1  store
done_in  in  1  instruction-retire marker, passed through
error_in  in  1  upstream exception, passed through
MemOp_in  in  3  [2]=unsigned, [1:0]=size (0 B, 1 H, 2 W, 3 D)
rd_in  in  5  destination register
alu_in  in  64  ALU result / effective address
store_in  in  64  store source data, LSB-justified
nxtpc_in  in  64  next PC
dmem_req  out  1  bus request
dmem_we  out  1  1=write
dmem_addr  out  ADDR_W  address with [2:0] forced to 0
dmem_wdata  out  64  lane-replicated store data
dmem_wmask  out  8  byte enables
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  response beat (loads and stores)
dmem_rdata  in  64  read beat
dmem_err  in  1  bus error, qualified by dmem_rvalid
out_valid, out_wen, out_MemRd, out_MemWr, out_done, out_error  out  1 each  registered bundle to WB
out_rd  out  5;  out_MemOp  out  3;  out_addr_low  out  3
out_data  out  64  ALU result passthrough
out_rdata  out  64  raw read beat
out_nxtpc  out  64

Behaviour:
- Reset (rst=0 at a posedge): FSM to IDLE, timeout counter to 0; dmem_req, dmem_we and all out_* control bits to 0; out_* data fields to 0.
- FSM states and transitions:
  - IDLE: in_ready=1.
    - in_valid with no memory op, or with error_in: out_* loaded next cycle with out_valid=1. Latency 1.
    - in_valid with a load or store: latch all inputs; go to REQ.
    - Misaligned access: out_error=1, no bus transaction, latency 1. Misaligned means H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0.
  - REQ: dmem_req=1; dmem_addr/we/wdata/wmask held stable. On dmem_gnt go to WAIT.
  - WAIT: dmem_req=0. On dmem_rvalid: register out_rdata=dmem_rdata, out_error=dmem_err, out_valid=1; return to IDLE.
  - in_ready=0 in REQ and WAIT.
- Minimum memory latency: accept at N, request at N+1, gnt at N+1, rvalid at N+2, out_valid at N+3.
- Timeout: counter clears on entry to REQ and to WAIT; increments each cycle in that state. When it reaches TIMEOUT: out_error=1, out_valid=1, return to IDLE.
- dmem_rvalid in IDLE or REQ is ignored.
- out_valid is a one-cycle pulse; it is 0 in every cycle without a completion.
- out_wen = wen_in AND NOT error. Error is error_in, misalignment, dmem_err or timeout.
- out_addr_low = addr[2:0]; out_MemOp = MemOp_in.
- Write mask:
  - B: 1 << addr[2:0]
  - H: 8'b11 << {addr[2:1],1'b0}
  - W: 8'h0F << {addr[2],2'b00}
  - D: 8'hFF
- Write data: B replicated 8x, H 4x, W 2x, D as-is. dmem_we=0 for loads.
- Reset mid-transaction: the transaction is abandoned and nothing is delivered to WB.

Test Plan:
- In IDLE, ADD with in_valid=1, wen_in=1, rd_in=5, alu_in=64'h1234 -> next cycle out_valid=1, out_wen=1, out_rd=5, out_data=64'h1234, in_ready stays 1.
- LB, alu_in=64'h8000_0003; gnt on first REQ cycle; rvalid next cycle with rdata=64'h1122334455667788 -> dmem_addr=64'h8000_0000, dmem_we=0, out_valid at N+3, out_rdata=64'h1122334455667788, out_addr_low=3, out_MemOp=0.
- SH store_in=64'hABCD, alu_in=64'h8000_0006 -> dmem_wmask=8'hC0, dmem_wdata=64'hABCDABCDABCDABCD, dmem_we=1; gnt delayed 4 cycles -> req and address stay stable throughout, in_ready=0 until completion.
- LW, alu_in=64'h8000_0002 -> no dmem_req ever; next cycle out_valid=1, out_error=1, out_wen=0.
- LD with gnt but no rvalid for TIMEOUT cycles -> out_error=1, out_valid=1, FSM back in IDLE; a late rvalid is ignored. Separately, dmem_err=1 with rvalid -> out_error=1, out_wen=0.
- rst=0 asserted while in WAIT -> next cycle dmem_req=0, out_valid=0, in_ready=1; a following ADD completes normally with latency 1.
